// File: rtl/soc_csr_bank.sv
// Generic CSR bank: byte-enabled RW words, write-one pulses, sticky W1C status with irq mask,
// and a read-to-pop receive queue with level/overflow reporting.
module soc_csr_bank #(
    parameter int unsigned N_RW = 4,
    parameter logic [N_RW*32-1:0] RW_INIT = '0,
    parameter int unsigned N_PULSE = 2,
    parameter int unsigned N_STAT = 8,
    parameter int unsigned RXQ_DEPTH = 4,
    parameter int unsigned RXQ_W = 8,
    parameter int unsigned ADDR_MSB = 7
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic                  vld,
    input  logic                  we,
    input  logic [ADDR_MSB:0]     addr,
    input  logic [31:0]           wdat,
    input  logic [3:0]            be,
    output logic [31:0]           rdat,
    output logic                  rdy,
    output logic [N_RW*32-1:0]    rw_q,
    output logic [N_PULSE-1:0]    pulse,
    input  logic [N_STAT-1:0]     stat_set,
    output logic                  irq,
    input  logic                  rxq_vld,
    input  logic [RXQ_W-1:0]      rxq_dat,
    output logic                  rxq_full
);

    localparam int unsigned AddrStat    = N_RW + N_PULSE;
    localparam int unsigned AddrIrqEn   = AddrStat + 1;
    localparam int unsigned AddrRxqData = AddrStat + 2;
    localparam int unsigned AddrRxqLvl  = AddrStat + 3;
    localparam int unsigned PW = $clog2(RXQ_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {StIdle, StResp} state_e;

    state_e                state_q, state_d;
    logic [N_RW*32-1:0]    rw_mem_q, rw_mem_d;
    logic [N_STAT-1:0]     stat_q, stat_d, en_q, en_d, stat_clr;
    logic [N_PULSE-1:0]    pulse_q, pulse_d;
    logic [31:0]           rdat_q, rdat_d, rd_val, widx;
    logic                  rdy_q, irq_q, irq_d, ovf_q, ovf_d;
    logic [RXQ_W-1:0]      mem_q [RXQ_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  go, wr_go, rd_go, empty, full, pop, push_ok, ovf_set, ovf_clr;
    logic                  unused_addr;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    assign unused_addr = ^addr[1:0];
    assign widx  = 32'(addr[ADDR_MSB:2]);
    // Only IDLE accepts a request, so a vld held through RESP is not re-executed.
    assign go    = vld && (state_q == StIdle);
    assign wr_go = go && we;
    assign rd_go = go && !we;

    assign empty    = (lvl_q == '0);
    assign full     = (lvl_q == LW'(RXQ_DEPTH));
    assign pop      = rd_go && (widx == AddrRxqData) && !empty;
    assign push_ok  = rxq_vld && (!full || pop);
    assign ovf_set  = rxq_vld && full && !pop;
    assign ovf_clr  = wr_go && (widx == AddrRxqLvl) && be[3] && wdat[31];
    assign stat_clr = (wr_go && (widx == AddrStat) && be[0]) ? wdat[N_STAT-1:0] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (vld) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (widx == i) rd_val = rw_mem_q[32*i +: 32];
        end
        if (widx == AddrStat)  rd_val = 32'(stat_q);
        if (widx == AddrIrqEn) rd_val = 32'(en_q);
        if (widx == AddrRxqData && !empty) rd_val = {1'b1, 31'(mem_q[rptr_q])};
        if (widx == AddrRxqLvl) rd_val = {ovf_q, 31'(lvl_q)};
    end

    always_comb begin
        rw_mem_d = rw_mem_q;
        en_d     = en_q;
        pulse_d  = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (wr_go && widx == i) rw_mem_d[32*i +: 32] = be_merge(rw_mem_q[32*i +: 32], wdat, be);
        end
        for (int unsigned i = 0; i < N_PULSE; i++) begin
            if (wr_go && widx == N_RW + i && be[0] && wdat[0]) pulse_d[i] = 1'b1;
        end
        if (wr_go && widx == AddrIrqEn) en_d = N_STAT'(be_merge(32'(en_q), wdat, be));
        // Set strobes are applied after the clear so a simultaneous set wins.
        stat_d = (stat_q & ~stat_clr) | stat_set;
        irq_d  = |(stat_d & en_d);
        ovf_d  = (ovf_q && !ovf_clr) || ovf_set;
        rdat_d = rd_go ? rd_val : '0;
        lvl_d  = lvl_q;
        if (push_ok && !pop) lvl_d = lvl_q + 1'b1;
        if (!push_ok && pop) lvl_d = lvl_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q  <= StIdle;
            rw_mem_q <= RW_INIT;
            stat_q   <= '0;
            en_q     <= '0;
            pulse_q  <= '0;
            rdat_q   <= '0;
            rdy_q    <= 1'b0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            lvl_q    <= '0;
        end else begin
            state_q  <= state_d;
            rw_mem_q <= rw_mem_d;
            stat_q   <= stat_d;
            en_q     <= en_d;
            pulse_q  <= pulse_d;
            rdat_q   <= rdat_d;
            rdy_q    <= go;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            lvl_q    <= lvl_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= rxq_dat;
    end

    assign rdat     = rdat_q;
    assign rdy      = rdy_q;
    assign rw_q     = rw_mem_q;
    assign pulse    = pulse_q;
    assign irq      = irq_q;
    assign rxq_full = full;

endmodule
